// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester beat bundle plus the shared FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         wfull;
  logic                         winc;
  logic [DATA_SIZE-1:0]         wdata;
  logic [IW-1:0]                grant_id;
  logic                         busy;
  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );
  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port, throttled by wfull.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  logic [0:0]    r_state;
  logic [IW-1:0] r_grant_id;
  logic [IW-1:0] r_last_id;
  logic [BW-1:0] r_beat_cnt;
  logic          w_busy;
  logic          w_winc;
  logic          w_release;
  logic          w_found;
  logic [IW-1:0] w_pick;
  // descending scan so the nearest index after r_last_id wins
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (bus.req_valid[(int'(r_last_id) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_last_id) + k) % NUM_REQ);
      end
  end
  assign w_busy    = (r_state == S_GRANT) && !rst;
  assign w_winc    = w_busy && bus.req_valid[r_grant_id] && !bus.wfull;
  assign w_release = w_winc && (bus.req_last[r_grant_id] || (r_beat_cnt + BW'(1)) == BW'(MAX_BURST));
  assign bus.busy      = w_busy;
  assign bus.winc      = w_winc;
  assign bus.req_ready = (w_busy && !bus.wfull) ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign bus.wdata     = w_busy ? bus.req_data[r_grant_id*DATA_SIZE +: DATA_SIZE] : '0;
  assign bus.grant_id  = rst ? '0 : r_grant_id;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_id  <= IW'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_found) begin
        r_state    <= S_GRANT;
        r_grant_id <= w_pick;
        r_beat_cnt <= '0;
      end
    end else if (w_winc) begin
      r_beat_cnt <= r_beat_cnt + BW'(1);
      if (w_release) begin
        r_state   <= S_IDLE;
        r_last_id <= r_grant_id;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_SIZE(DW)) bus();
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  int left[N], pkt[N], beat[N], seq[N];
  logic [DW-1:0] base[N];
  bit gaps = 0;
  logic wfull_v = 1'b0;
  bit m_busy = 0;
  int m_gid = 0, m_last = N - 1, m_cnt = 0;
  bit o_busy, o_winc;
  logic [N-1:0] o_ready;
  logic [DW-1:0] o_wdata;
  int o_gid;
  bit prev_busy, had;
  int gap, cur_w, acc;
  int grant_q[$], wincs_q[$], gap_q[$];
  logic [DW-1:0] wd_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = left[i] != 0 && (!gaps || $urandom_range(3) != 0);
      bus.req_data[i*DW +: DW] = base[i] + DW'(seq[i]);
      bus.req_last[i] = pkt[i] != 0 && beat[i] == pkt[i] - 1;
    end
    bus.wfull = wfull_v;
  endtask

  task automatic cycle();
    bit e_busy, e_winc, ll;
    logic [N-1:0] e_ready;
    int e_gid, best, bd, d;
    drive();
    @(negedge clk);
    e_busy  = m_busy && !rst;
    e_winc  = e_busy && bus.req_valid[m_gid] && !bus.wfull;
    e_ready = (e_busy && !bus.wfull) ? N'(1) << m_gid : '0;
    e_gid   = rst ? 0 : m_gid;
    ll      = bus.req_last[m_gid];
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("winc", 32'(bus.winc), 32'(e_winc));
    chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
    chk("grant_id", 32'(bus.grant_id), e_gid);
    if (e_busy) chk("wdata", 32'(bus.wdata), 32'(bus.req_data[m_gid*DW +: DW]));
    o_busy = bus.busy; o_winc = bus.winc; o_ready = bus.req_ready;
    o_wdata = bus.wdata; o_gid = int'(bus.grant_id);
    if (o_busy && !prev_busy) begin
      if (had) gap_q.push_back(gap);
      grant_q.push_back(o_gid);
      cur_w = 0;
      had = 1;
    end
    if (o_busy && o_winc) begin
      cur_w++;
      acc++;
      wd_q.push_back(o_wdata);
    end
    if (!o_busy && prev_busy) begin
      wincs_q.push_back(cur_w);
      gap = 0;
    end
    if (!o_busy) gap++;
    prev_busy = o_busy;
    if (e_winc) begin
      seq[m_gid]++;
      left[m_gid]--;
      beat[m_gid] = ll ? 0 : beat[m_gid] + 1;
    end
    // the grantee is the valid requester at the smallest rotational distance past the pointer
    if (rst) begin
      m_busy = 0; m_last = N - 1; m_gid = 0; m_cnt = 0;
    end else if (!m_busy) begin
      best = -1; bd = N;
      for (int j = 0; j < N; j++)
        if (bus.req_valid[j]) begin
          d = (j - m_last - 1 + 2 * N) % N;
          if (d < bd) begin best = j; bd = d; end
        end
      if (best >= 0) begin m_busy = 1; m_gid = best; m_cnt = 0; end
    end else if (e_winc) begin
      m_cnt++;
      if (ll || m_cnt == MB) begin m_busy = 0; m_last = m_gid; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_q.delete(); wincs_q.delete(); gap_q.delete(); wd_q.delete();
    prev_busy = 0; had = 0; gap = 0; cur_w = 0; acc = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      left[i] = 0; pkt[i] = 0; beat[i] = 0; seq[i] = 0; base[i] = DW'(i * 16);
    end
    wfull_v = 1'b0;
    gaps = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    do_reset();
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_winc", 32'(o_winc), 0);
    chk("reset_gid", o_gid, 0);
    cycle();
    chk("post_reset_idle", 32'(o_busy), 0);
    // single one-beat packet from requester 0
    left[0] = 1; pkt[0] = 1; base[0] = 8'hA5;
    cycle();
    chk("t1_arb_cycle_busy", 32'(o_busy), 0);
    cycle();
    chk("t1_busy", 32'(o_busy), 1);
    chk("t1_winc", 32'(o_winc), 1);
    chk("t1_wdata", 32'(o_wdata), 32'h A5);
    cycle();
    chk("t1_back_idle", 32'(o_busy), 0);
    chk("t1_idle_winc", 32'(o_winc), 0);
    cycle();
    chk("t1_beats", acc, 1);
    // all four requesters, 2-beat packets
    do_reset();
    for (int i = 0; i < N; i++) begin left[i] = 4; pkt[i] = 2; end
    for (int n = 0; n < 40 && grant_q.size() < 6; n++) cycle();
    chk("t2_g0", grant_q.size() > 0 ? grant_q[0] : -1, 0);
    chk("t2_g1", grant_q.size() > 1 ? grant_q[1] : -1, 1);
    chk("t2_g2", grant_q.size() > 2 ? grant_q[2] : -1, 2);
    chk("t2_g3", grant_q.size() > 3 ? grant_q[3] : -1, 3);
    chk("t2_g4", grant_q.size() > 4 ? grant_q[4] : -1, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t2_beats_per_grant", wincs_q.size() > k ? wincs_q[k] : -1, 2);
      chk("t2_bubble", gap_q.size() > k ? gap_q[k] : -1, 1);
    end
    for (int n = 0; n < 40 && (left[0] | left[1] | left[2] | left[3]) != 0; n++) cycle();
    // requester 2 alone, never last: MAX_BURST release then re-grant
    do_reset();
    left[2] = 8;
    for (int n = 0; n < 40 && left[2] != 0; n++) cycle();
    cycle(); cycle();
    chk("t3_g0", grant_q.size() > 0 ? grant_q[0] : -1, 2);
    chk("t3_g1", grant_q.size() > 1 ? grant_q[1] : -1, 2);
    chk("t3_burst0", wincs_q.size() > 0 ? wincs_q[0] : -1, 4);
    chk("t3_burst1", wincs_q.size() > 1 ? wincs_q[1] : -1, 4);
    chk("t3_bubble", gap_q.size() > 0 ? gap_q[0] : -1, 1);
    // mid-burst stall
    do_reset();
    left[1] = 4; pkt[1] = 4;
    for (int n = 0; n < 10 && acc < 1; n++) cycle();
    chk("t4_first_beat", acc, 1);
    wfull_v = 1'b1;
    repeat (3) begin
      cycle();
      chk("t4_stall_winc", 32'(o_winc), 0);
      chk("t4_stall_ready", 32'(o_ready), 0);
      chk("t4_stall_held", 32'(o_busy), 1);
    end
    wfull_v = 1'b0;
    for (int n = 0; n < 20 && left[1] != 0; n++) cycle();
    cycle(); cycle();
    chk("t4_grants", grant_q.size(), 1);
    chk("t4_total", wincs_q.size() > 0 ? wincs_q[0] : -1, 4);
    for (int k = 0; k < 4; k++)
      chk("t4_data_order", wd_q.size() > k ? 32'(wd_q[k]) : 32'hFFFF, 32'h10 + k);
    // reset during beat 2 of requester 3
    do_reset();
    left[3] = 4; pkt[3] = 4;
    for (int n = 0; n < 10 && acc < 1; n++) cycle();
    chk("t5_first_beat", acc, 1);
    rst = 1'b1;
    cycle();
    chk("t5_rst_winc", 32'(o_winc), 0);
    chk("t5_rst_busy", 32'(o_busy), 0);
    chk("t5_rst_ready", 32'(o_ready), 0);
    chk("t5_rst_gid", o_gid, 0);
    rst = 1'b0;
    left[0] = 2; pkt[0] = 2; beat[0] = 0; seq[0] = 0; base[0] = 8'h50;
    cycle();
    chk("t5_after_busy", 32'(o_busy), 0);
    chk("t5_after_winc", 32'(o_winc), 0);
    cycle();
    chk("t5_regrant_busy", 32'(o_busy), 1);
    chk("t5_regrant_gid", o_gid, 0);
    chk("t5_regrant_wdata", 32'(o_wdata), 32'h50);
    // randomized traffic, stalls and occasional resets
    do_reset();
    gaps = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        if (left[i] == 0 && $urandom_range(3) == 0) begin
          left[i] = $urandom_range(10, 1);
          pkt[i] = $urandom_range(5);
          beat[i] = 0;
        end
      wfull_v = $urandom_range(3) == 0;
      rst = $urandom_range(399) == 0;
      cycle();
    end
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
